microseq_addr_unit: RTL and testbench
=====================================

Name: microseq_addr_unit

Overview:
- Parametrised microprogram sequencer for the multicycle RISC-V control unit; holds the micro-PC and selects its next value each cycle.
- Supported next-address sources:
  - sequential increment
  - two programmable opcode dispatch tables
  - fetch vector
  - literal jump
  - micro-call/return through a bounded return stack
- Adds stall and error reporting: dispatch misses, stack overflow and stack underflow redirect to a trap vector.

Parameters:
- ADDR_W, 4, micro-PC width in bits.
- OP_W, 7, opcode width.
- DISP_ENTRIES, 8, entries per dispatch table (two tables, DISP0 and DISP1).
- STACK_DEPTH, 4, return-stack entries (>=1).
- FETCH_ADDR, 0, fetch vector and reset value of upc.
- TRAP_ADDR, 2**ADDR_W-1, vector taken on any error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- advance  in  1  1 = sequencer steps this cycle; 0 = stall.
- op  in  OP_W  opcode of the current instruction.
- addr_ctl  in  3  next-address select, encoded under Behaviour.
- jump_addr  in  ADDR_W  target for JUMP and CALL.
- cfg_we  in  1  dispatch-table write enable.
- cfg_tbl  in  1  0 = DISP0, 1 = DISP1.
- cfg_idx  in  $clog2(DISP_ENTRIES)  entry index.
- cfg_valid  in  1  entry valid bit to write.
- cfg_op  in  OP_W  entry match opcode.
- cfg_target  in  ADDR_W  entry target address.
- upc  out  ADDR_W  registered micro-PC.
- stack_level  out  $clog2(STACK_DEPTH+1)  number of occupied return-stack entries.
- disp_miss  out  1  one-cycle pulse: dispatch found no match.
- stack_ovf  out  1  one-cycle pulse: CALL with the stack full.
- stack_unf  out  1  one-cycle pulse: RET with the stack empty.

Behaviour:
- Reset (synchronous, active-high):
  - upc=FETCH_ADDR, stack_level=0, all table entries invalid.
  - disp_miss, stack_ovf, stack_unf = 0.
  - Reset has priority over advance and cfg_we; asserting it mid-sequence discards stack contents.
- Latency: when advance=1, the next upc is computed from the current upc, op, addr_ctl and jump_addr, and registered on the same edge. The new value is visible the cycle after the edge.
- addr_ctl encoding when advance=1:
  - 000 SEQ: upc+1, modulo 2**ADDR_W; all-ones wraps to 0.
  - 001 DISP0: target of the lowest-index valid DISP0 entry with entry.op==op. No match -> TRAP_ADDR, disp_miss=1.
  - 010 DISP1: same lookup on DISP1.
  - 011 FETCH: FETCH_ADDR.
  - 100 JUMP: jump_addr.
  - 101 CALL:
    - If stack_level<STACK_DEPTH: push upc+1 (wrapped), stack_level+1, upc=jump_addr.
    - If full: no push, upc=TRAP_ADDR, stack_ovf=1.
  - 110 RET:
    - If stack_level>0: upc=top of stack, pop, stack_level-1.
    - If empty: upc=TRAP_ADDR, stack_unf=1.
  - 111 reserved: upc holds, no side effects.
- Stall (advance=0):
  - upc, stack and stack_level hold.
  - All error pulses are 0.
  - Dispatch-table writes still occur.
- Error pulses: registered, high exactly one cycle after the offending edge unless the next edge repeats the error. At most one error asserts per cycle.
- Table writes: when cfg_we=1, entry [cfg_tbl][cfg_idx] gets {cfg_valid, cfg_op, cfg_target} on the edge.
  - A lookup in the same cycle sees the pre-write contents; the write becomes visible on the next cycle.
  - cfg_valid=0 invalidates the entry.
- Duplicate opcodes in one table are legal; the lowest index wins.
- Return stack is LIFO. Entries above stack_level are don't-care and are not cleared on pop.

Test Plan:
- Reset then advance=1, addr_ctl=000 for 16 cycles (ADDR_W=4) -> upc runs 0,1,…,15 then 0 on the following cycle; no error pulses.
- Program DISP0[0]={1,0110011,6}, DISP1[2]={1,0000011,3}. With op=0110011, ctl=001 -> upc=6. With op=0000011, ctl=010 -> upc=3. With op=1111111, ctl=001 -> upc=15 and disp_miss high for one cycle.
- From upc=2: CALL jump_addr=9 -> upc=9, stack_level=1. CALL jump_addr=12 -> upc=12, level=2. RET -> upc=10. RET -> upc=3, level=0. RET -> upc=15, stack_unf pulse.
- With STACK_DEPTH=4, five CALLs to 8 -> after the fourth, level=4. Fifth -> upc=15, stack_ovf pulse, level stays 4.
- Hold advance=0 while toggling addr_ctl and op, and write DISP0[1]={1,0010011,8} -> upc and level unchanged, no pulses. Then advance=1, op=0010011, ctl=001 -> upc=8.
- Write DISP0[0] target 5 in the same cycle as a DISP0 lookup hitting entry 0 (old target 6) -> upc=6. Repeat the lookup -> upc=5. Assert reset mid-CALL chain -> upc=0, stack_level=0, tables invalid (a subsequent dispatch misses).

Source files
------------

// File: rtl/microseq_addr_unit_if.sv
// microseq_addr_unit_if: control, table-config and status bundle of the micro-PC sequencer
interface microseq_addr_unit_if #(
    parameter int ADDR_W       = 4,
    parameter int OP_W         = 7,
    parameter int DISP_ENTRIES = 8,
    parameter int STACK_DEPTH  = 4
);
    localparam int IDX_W = $clog2(DISP_ENTRIES);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    logic              advance;
    logic [OP_W-1:0]   op;
    logic [2:0]        addr_ctl;
    logic [ADDR_W-1:0] jump_addr;
    logic              cfg_we;
    logic              cfg_tbl;
    logic [IDX_W-1:0]  cfg_idx;
    logic              cfg_valid;
    logic [OP_W-1:0]   cfg_op;
    logic [ADDR_W-1:0] cfg_target;
    logic [ADDR_W-1:0] upc;
    logic [LVL_W-1:0]  stack_level;
    logic              disp_miss;
    logic              stack_ovf;
    logic              stack_unf;
    modport master (
        output advance, op, addr_ctl, jump_addr, cfg_we, cfg_tbl, cfg_idx, cfg_valid, cfg_op, cfg_target,
        input  upc, stack_level, disp_miss, stack_ovf, stack_unf
    );
    modport slave (
        input  advance, op, addr_ctl, jump_addr, cfg_we, cfg_tbl, cfg_idx, cfg_valid, cfg_op, cfg_target,
        output upc, stack_level, disp_miss, stack_ovf, stack_unf
    );
endinterface

// File: rtl/microseq_addr_unit.sv
// microseq_addr_unit: micro-PC sequencer with dispatch tables, return stack and trap redirection
module microseq_addr_unit #(
    parameter int                ADDR_W       = 4,
    parameter int                OP_W         = 7,
    parameter int                DISP_ENTRIES = 8,
    parameter int                STACK_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] FETCH_ADDR   = '0,
    parameter logic [ADDR_W-1:0] TRAP_ADDR    = '1
) (
    input logic                 clk,
    input logic                 reset,
    microseq_addr_unit_if.slave bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int SP_W  = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [ADDR_W-1:0] upc_q, upc_d, upc_inc;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
    logic              push;
    logic              miss_q, miss_d, ovf_q, ovf_d, unf_q, unf_d;
    logic              vld_q [2][DISP_ENTRIES];
    logic [OP_W-1:0]   dop_q [2][DISP_ENTRIES];
    logic [ADDR_W-1:0] dtg_q [2][DISP_ENTRIES];
    logic              tsel, hit;
    logic [ADDR_W-1:0] hit_tgt;
    assign upc_inc = upc_q + 1'b1;
    assign tsel    = bus.addr_ctl[1];
    // Table lookup scans from the top down so the lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        hit_tgt = '0;
        for (int i = DISP_ENTRIES - 1; i >= 0; i--) begin
            if (vld_q[tsel][i] && dop_q[tsel][i] == bus.op) begin
                hit     = 1'b1;
                hit_tgt = dtg_q[tsel][i];
            end
        end
    end
    // Next micro-PC, stack depth and error flags; everything holds while stalled
    always_comb begin
        upc_d  = upc_q;
        lvl_d  = lvl_q;
        push   = 1'b0;
        miss_d = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (bus.advance) begin
            case (bus.addr_ctl)
                3'b000: upc_d = upc_inc;
                3'b001, 3'b010: begin
                    upc_d  = hit ? hit_tgt : TRAP_ADDR;
                    miss_d = !hit;
                end
                3'b011: upc_d = FETCH_ADDR;
                3'b100: upc_d = bus.jump_addr;
                3'b101: begin
                    if (lvl_q < LVL_W'(STACK_DEPTH)) begin
                        push  = 1'b1;
                        lvl_d = lvl_q + 1'b1;
                        upc_d = bus.jump_addr;
                    end else begin
                        upc_d = TRAP_ADDR;
                        ovf_d = 1'b1;
                    end
                end
                3'b110: begin
                    if (lvl_q != '0) begin
                        upc_d = stk_q[SP_W'(lvl_q - 1'b1)];
                        lvl_d = lvl_q - 1'b1;
                    end else begin
                        upc_d = TRAP_ADDR;
                        unf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    // State update; reset clears only valid bits, stack and table payloads need no reset
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q  <= FETCH_ADDR;
            lvl_q  <= '0;
            miss_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            for (int t = 0; t < 2; t++)
                for (int i = 0; i < DISP_ENTRIES; i++)
                    vld_q[t][i] <= 1'b0;
        end else begin
            upc_q  <= upc_d;
            lvl_q  <= lvl_d;
            miss_q <= miss_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            if (push)
                stk_q[SP_W'(lvl_q)] <= upc_inc;
            if (bus.cfg_we) begin
                vld_q[bus.cfg_tbl][bus.cfg_idx] <= bus.cfg_valid;
                dop_q[bus.cfg_tbl][bus.cfg_idx] <= bus.cfg_op;
                dtg_q[bus.cfg_tbl][bus.cfg_idx] <= bus.cfg_target;
            end
        end
    end
    assign bus.upc         = upc_q;
    assign bus.stack_level = lvl_q;
    assign bus.disp_miss   = miss_q;
    assign bus.stack_ovf   = ovf_q;
    assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_microseq_addr_unit.sv
// tb_microseq_addr_unit: table-driven and directed checks of the micro-PC sequencer
module tb_microseq_addr_unit;
    localparam logic [2:0] SEQ = 3'b000, D0 = 3'b001, D1 = 3'b010, FET = 3'b011;
    localparam logic [2:0] JMP = 3'b100, CAL = 3'b101, RET = 3'b110, RSV = 3'b111;
    localparam logic [2:0] NOE = 3'b000, MISS = 3'b100, OVF = 3'b010, UNF = 3'b001;
    typedef struct {
        logic       adv;
        logic [2:0] ctl;
        logic [6:0] op;
        logic [3:0] ja;
        logic [3:0] eu;
        logic [2:0] el;
        logic [2:0] ee;
    } vec_t;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];
    always #5 clk = ~clk;
    microseq_addr_unit_if bus ();
    microseq_addr_unit dut (.clk(clk), .reset(reset), .bus(bus));
    function automatic vec_t mk(logic adv, logic [2:0] ctl, logic [6:0] op, logic [3:0] ja,
                                logic [3:0] eu, logic [2:0] el, logic [2:0] ee);
        vec_t v;
        v.adv = adv; v.ctl = ctl; v.op = op; v.ja = ja; v.eu = eu; v.el = el; v.ee = ee;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [3:0] eu, input logic [2:0] el, input logic [2:0] ee);
        logic [2:0] err;
        err = {bus.disp_miss, bus.stack_ovf, bus.stack_unf};
        checks++;
        if ({bus.upc, bus.stack_level, err} !== {eu, el, ee}) begin
            errors++;
            $display("FAIL %s: got upc=%0d lvl=%0d err=%b, want upc=%0d lvl=%0d err=%b",
                     nm, bus.upc, bus.stack_level, err, eu, el, ee);
        end
    endtask
    task automatic step(input logic adv, input logic [2:0] ctl, input logic [6:0] op, input logic [3:0] ja);
        bus.advance   = adv;
        bus.addr_ctl  = ctl;
        bus.op        = op;
        bus.jump_addr = ja;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask
    task automatic cfg(input logic tbl, input logic [2:0] idx, input logic valid, input logic [6:0] op, input logic [3:0] tgt);
        bus.cfg_we     = 1'b1;
        bus.cfg_tbl    = tbl;
        bus.cfg_idx    = idx;
        bus.cfg_valid  = valid;
        bus.cfg_op     = op;
        bus.cfg_target = tgt;
    endtask
    task automatic run_table(input string nm);
        foreach (vq[i]) begin
            step(vq[i].adv, vq[i].ctl, vq[i].op, vq[i].ja);
            chk($sformatf("%s[%0d]", nm, i), vq[i].eu, vq[i].el, vq[i].ee);
        end
        vq.delete();
    endtask
    initial begin
        reset = 1'b1;
        bus.advance = 1'b0; bus.op = '0; bus.addr_ctl = SEQ; bus.jump_addr = '0;
        bus.cfg_we = 1'b0; bus.cfg_tbl = 1'b0; bus.cfg_idx = '0; bus.cfg_valid = 1'b0;
        bus.cfg_op = '0; bus.cfg_target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 4'd0, 3'd0, NOE);
        reset = 1'b0;
        for (int i = 1; i <= 16; i++)
            vq.push_back(mk(1'b1, SEQ, 7'd0, 4'd0, 4'(i % 16), 3'd0, NOE));
        run_table("seq");
        cfg(1'b0, 3'd0, 1'b1, 7'b0110011, 4'd6);
        step(1'b0, SEQ, 7'd0, 4'd0);
        chk("cfg_w0", 4'd0, 3'd0, NOE);
        cfg(1'b1, 3'd2, 1'b1, 7'b0000011, 4'd3);
        step(1'b0, SEQ, 7'd0, 4'd0);
        chk("cfg_w1", 4'd0, 3'd0, NOE);
        vq.push_back(mk(1'b1, D0,  7'b0110011, 4'd0,  4'd6,  3'd0, NOE));
        vq.push_back(mk(1'b1, D1,  7'b0000011, 4'd0,  4'd3,  3'd0, NOE));
        vq.push_back(mk(1'b1, D0,  7'b1111111, 4'd0,  4'd15, 3'd0, MISS));
        vq.push_back(mk(1'b1, SEQ, 7'd0,       4'd0,  4'd0,  3'd0, NOE));
        vq.push_back(mk(1'b1, JMP, 7'd0,       4'd2,  4'd2,  3'd0, NOE));
        vq.push_back(mk(1'b1, CAL, 7'd0,       4'd9,  4'd9,  3'd1, NOE));
        vq.push_back(mk(1'b1, CAL, 7'd0,       4'd12, 4'd12, 3'd2, NOE));
        vq.push_back(mk(1'b1, RET, 7'd0,       4'd0,  4'd10, 3'd1, NOE));
        vq.push_back(mk(1'b1, RET, 7'd0,       4'd0,  4'd3,  3'd0, NOE));
        vq.push_back(mk(1'b1, RET, 7'd0,       4'd0,  4'd15, 3'd0, UNF));
        vq.push_back(mk(1'b1, FET, 7'd0,       4'd5,  4'd0,  3'd0, NOE));
        vq.push_back(mk(1'b1, CAL, 7'd0,       4'd8,  4'd8,  3'd1, NOE));
        vq.push_back(mk(1'b1, CAL, 7'd0,       4'd8,  4'd8,  3'd2, NOE));
        vq.push_back(mk(1'b1, CAL, 7'd0,       4'd8,  4'd8,  3'd3, NOE));
        vq.push_back(mk(1'b1, CAL, 7'd0,       4'd8,  4'd8,  3'd4, NOE));
        vq.push_back(mk(1'b1, CAL, 7'd0,       4'd8,  4'd15, 3'd4, OVF));
        vq.push_back(mk(1'b1, CAL, 7'd0,       4'd8,  4'd15, 3'd4, OVF));
        vq.push_back(mk(1'b1, RSV, 7'd0,       4'd3,  4'd15, 3'd4, NOE));
        vq.push_back(mk(1'b1, RET, 7'd0,       4'd0,  4'd9,  3'd3, NOE));
        vq.push_back(mk(1'b1, RET, 7'd0,       4'd0,  4'd9,  3'd2, NOE));
        vq.push_back(mk(1'b1, RET, 7'd0,       4'd0,  4'd9,  3'd1, NOE));
        vq.push_back(mk(1'b1, RET, 7'd0,       4'd0,  4'd1,  3'd0, NOE));
        vq.push_back(mk(1'b1, RET, 7'd0,       4'd0,  4'd15, 3'd0, UNF));
        vq.push_back(mk(1'b1, RET, 7'd0,       4'd0,  4'd15, 3'd0, UNF));
        run_table("main");
        cfg(1'b0, 3'd1, 1'b1, 7'b0010011, 4'd8);
        step(1'b0, D0, 7'b0010011, 4'd3);
        chk("stall0", 4'd15, 3'd0, NOE);
        step(1'b0, CAL, 7'b1111111, 4'd5);
        chk("stall1", 4'd15, 3'd0, NOE);
        step(1'b0, RET, 7'b0000000, 4'd0);
        chk("stall2", 4'd15, 3'd0, NOE);
        step(1'b0, JMP, 7'b0110011, 4'd4);
        chk("stall3", 4'd15, 3'd0, NOE);
        step(1'b1, D0, 7'b0010011, 4'd0);
        chk("disp_after_stall", 4'd8, 3'd0, NOE);
        cfg(1'b0, 3'd3, 1'b1, 7'b0010011, 4'd4);
        step(1'b0, SEQ, 7'd0, 4'd0);
        chk("dup_write", 4'd8, 3'd0, NOE);
        step(1'b1, D0, 7'b0010011, 4'd0);
        chk("dup_lowest", 4'd8, 3'd0, NOE);
        cfg(1'b0, 3'd0, 1'b1, 7'b0110011, 4'd5);
        step(1'b1, D0, 7'b0110011, 4'd0);
        chk("wr_same_cycle", 4'd6, 3'd0, NOE);
        step(1'b1, D0, 7'b0110011, 4'd0);
        chk("wr_visible", 4'd5, 3'd0, NOE);
        cfg(1'b0, 3'd1, 1'b0, 7'b0010011, 4'd8);
        step(1'b0, SEQ, 7'd0, 4'd0);
        chk("inval_write", 4'd5, 3'd0, NOE);
        step(1'b1, D0, 7'b0010011, 4'd0);
        chk("inval_next", 4'd4, 3'd0, NOE);
        step(1'b1, CAL, 7'd0, 4'd7);
        chk("chain0", 4'd7, 3'd1, NOE);
        step(1'b1, CAL, 7'd0, 4'd11);
        chk("chain1", 4'd11, 3'd2, NOE);
        reset = 1'b1;
        cfg(1'b1, 3'd0, 1'b1, 7'b0000011, 4'd7);
        step(1'b1, CAL, 7'd0, 4'd13);
        chk("mid_reset", 4'd0, 3'd0, NOE);
        reset = 1'b0;
        step(1'b1, D0, 7'b0110011, 4'd0);
        chk("post_reset_d0", 4'd15, 3'd0, MISS);
        step(1'b1, D1, 7'b0000011, 4'd0);
        chk("post_reset_d1", 4'd15, 3'd0, MISS);
        step(1'b1, RET, 7'd0, 4'd0);
        chk("post_reset_ret", 4'd15, 3'd0, UNF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
